// File: rtl/rv32_fetch_pkg.sv
// ---------------------------------------------------------------------------
// rv32_fetch_pkg
// Shared types and constants for the instruction fetch front end:
//   fetch_state_t - fetch FSM states (IDLE, REQ, WAIT, DRAIN)
//   NOP_INSTR     - instruction substituted for a misaligned fetch (addi x0,x0,0)
//   fetch_entry_t - one instruction buffer entry {instr, pc, fault}
// ---------------------------------------------------------------------------
package rv32_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,   // may issue a fetch or insert a fault NOP
        REQ,    // request on the bus, waiting for ack
        WAIT,   // request accepted, waiting for read data
        DRAIN   // request accepted before a flush; its data will be dropped
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } fetch_entry_t;

endpackage

// File: rtl/rv32_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// rv32_fetch_unit_if
// Bus bundle of the fetch unit: the instruction memory read channel
// (req/ack + rvalid) and the instruction channel towards decode
// (valid/ready plus head entry fields).
//   master - fetch unit side
//   slave  - memory/decode side
// ---------------------------------------------------------------------------
interface rv32_fetch_unit_if;

    // instruction memory read channel
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ack_in;
    logic        imem_rvalid_in;
    logic [31:0] imem_rdata_in;

    // instruction channel towards decode
    logic        instr_valid_out;
    logic        instr_ready_in;
    logic [31:0] instr_out;
    logic [31:0] instr_pc_out;
    logic        instr_fault_out;

    modport master (
        output imem_req_out, imem_addr_out,
        input  imem_ack_in, imem_rvalid_in, imem_rdata_in,
        output instr_valid_out, instr_out, instr_pc_out, instr_fault_out,
        input  instr_ready_in
    );

    modport slave (
        input  imem_req_out, imem_addr_out,
        output imem_ack_in, imem_rvalid_in, imem_rdata_in,
        input  instr_valid_out, instr_out, instr_pc_out, instr_fault_out,
        output instr_ready_in
    );

endinterface

// File: rtl/rv32_fetch_fifo.sv
// ---------------------------------------------------------------------------
// rv32_fetch_fifo
// Synchronous instruction buffer with synchronous clear.
//   mp_clk_in  - clock, rising edge
//   mp_rst_in  - asynchronous reset, active-low
//   clear      - empty the buffer (wins over push/pop)
//   push       - write wr_data at the tail (caller guarantees a free slot)
//   wr_data    - entry to write
//   pop        - drop the head entry (ignored when empty)
//   count      - number of valid entries
//   head       - head entry; holds its last value when empty
// ---------------------------------------------------------------------------
module rv32_fetch_fifo
    import rv32_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   mp_clk_in,
    input  logic                   mp_rst_in,
    input  logic                   clear,
    input  logic                   push,
    input  fetch_entry_t           wr_data,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [PW:0]   CNT_ONE = 1;

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count_q;
    logic          do_pop;

    assign do_pop = pop && (count_q != '0);

    // NOTE: sequential state is written only with non-blocking (<=) assignments,
    // so every flop samples pre-edge values regardless of statement order.
    // NOTE: the storage array is reset as well; it is only a few entries and it
    // keeps the head outputs at zero while reset is asserted.
    always_ff @(posedge mp_clk_in or negedge mp_rst_in) begin
        if (!mp_rst_in) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count = count_q;
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/rv32_fetch_unit.sv
// ---------------------------------------------------------------------------
// rv32_fetch_unit
// Instruction fetch front end sitting after the PC register. Reads one word
// at a time from instruction memory and buffers the results for decode.
//   mp_clk_in       - clock, rising edge
//   mp_rst_in       - asynchronous reset, active-low
//   pc_in           - current PC from the PC register
//   pc_advance_out  - pulse: PC mux selects pc_in+4 for the next edge
//   flush_in        - redirect; the PC register loads the target on this edge
//   bus (master)    - imem req/ack/rvalid channel and decode valid/ready channel
// At most one memory request is outstanding. A buffer slot is reserved when a
// request is issued, so returning data always has room.
// ---------------------------------------------------------------------------
module rv32_fetch_unit
    import rv32_fetch_pkg::fetch_state_t, rv32_fetch_pkg::fetch_entry_t,
           rv32_fetch_pkg::IDLE, rv32_fetch_pkg::REQ,
           rv32_fetch_pkg::WAIT, rv32_fetch_pkg::DRAIN;
#(
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = rv32_fetch_pkg::NOP_INSTR
) (
    input  logic              mp_clk_in,
    input  logic              mp_rst_in,
    input  logic [31:0]       pc_in,
    output logic              pc_advance_out,
    input  logic              flush_in,
    rv32_fetch_unit_if.master bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state_q;
    fetch_state_t  state_d;
    logic [31:0]   addr_q;
    logic          addr_load;
    logic          req;
    logic          adv;
    logic          push;
    logic          pop;
    logic          in_flight;
    logic          has_slot;
    logic          head_valid;
    logic [CW-1:0] count;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    // Reserved slots = buffered entries + the one outstanding request.
    assign in_flight  = (state_q == REQ) || (state_q == WAIT);
    assign has_slot   = (count + CW'(in_flight)) < CW'(FIFO_DEPTH);
    assign head_valid = (count != '0);
    assign pop        = head_valid && bus.instr_ready_in;

    always_ff @(posedge mp_clk_in or negedge mp_rst_in) begin
        if (!mp_rst_in) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (addr_load) begin
                addr_q <= pc_in;
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        addr_load  = 1'b0;
        req        = 1'b0;
        adv        = 1'b0;
        push       = 1'b0;
        push_entry = '0;
        unique case (state_q)
            IDLE: begin
                // A redirect this cycle means pc_in is stale; wait for the target.
                if (!flush_in && has_slot) begin
                    if (pc_in[1:0] == 2'b00) begin
                        addr_load = 1'b1;
                        state_d   = REQ;
                    end else begin
                        push       = 1'b1;
                        push_entry = '{instr: NOP_INSTR, pc: pc_in, fault: 1'b1};
                        adv        = 1'b1;
                    end
                end
            end
            REQ: begin
                req = 1'b1;
                if (flush_in) begin
                    // An accepted request still returns data that must be swallowed.
                    state_d = bus.imem_ack_in ? DRAIN : IDLE;
                end else if (bus.imem_ack_in) begin
                    adv     = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (flush_in) begin
                    state_d = bus.imem_rvalid_in ? IDLE : DRAIN;
                end else if (bus.imem_rvalid_in) begin
                    push       = 1'b1;
                    push_entry = '{instr: bus.imem_rdata_in, pc: addr_q, fault: 1'b0};
                    state_d    = IDLE;
                end
            end
            DRAIN: begin
                if (bus.imem_rvalid_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    rv32_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .mp_clk_in (mp_clk_in),
        .mp_rst_in (mp_rst_in),
        .clear     (flush_in),
        .push      (push),
        .wr_data   (push_entry),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

    // The IDLE fault path is combinational on pc_in; keep it quiet under reset.
    assign pc_advance_out      = adv & mp_rst_in;
    assign bus.imem_req_out    = req;
    assign bus.imem_addr_out   = addr_q;
    assign bus.instr_valid_out = head_valid;
    assign bus.instr_out       = head.instr;
    assign bus.instr_pc_out    = head.pc;
    assign bus.instr_fault_out = head.fault;

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_rv32_fetch_unit
// Self-checking bench for rv32_fetch_unit. The bench owns the PC register,
// an instruction memory and a program-order model: every pc_advance_out
// consumes the current PC and appends the instruction expected for it; a
// flush discards everything not yet accepted by decode.
// ---------------------------------------------------------------------------
module tb_rv32_fetch_unit;

    localparam int FIFO_DEPTH = 2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    logic        mp_clk_in = 1'b0;
    logic        mp_rst_in = 1'b0;
    logic [31:0] pc_in     = '0;
    logic        pc_advance_out;
    logic        flush_in  = 1'b0;

    rv32_fetch_unit_if bus ();

    rv32_fetch_unit #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .NOP_INSTR  (32'h0000_0013)
    ) dut (
        .mp_clk_in      (mp_clk_in),
        .mp_rst_in      (mp_rst_in),
        .pc_in          (pc_in),
        .pc_advance_out (pc_advance_out),
        .flush_in       (flush_in),
        .bus            (bus)
    );

    always #5 mp_clk_in = ~mp_clk_in;

    // bookkeeping
    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        exp_q[$];
    logic [31:0] pc_reg   = '0;

    // stimulus policy
    bit          flush_next = 1'b0;
    logic [31:0] flush_tgt  = '0;
    bit          force_ack  = 1'b0;
    int          ack_pct    = 100;
    int          lat_min    = 2;
    int          lat_max    = 2;
    int          ready_pct  = 0;
    int          flush_pct  = 0;

    // memory model
    bit          pending = 1'b0;
    int          rv_cnt  = 0;
    logic [31:0] rv_addr = '0;

    // event counters
    int          adv_count    = 0;
    int          acc_count    = 0;
    int          rvalid_count = 0;
    int          pop_count    = 0;
    logic [31:0] last_acc_addr = '0;
    logic [31:0] last_pop_pc   = '0;
    bit          watch_en  = 1'b0;
    logic [31:0] watch_pc  = '0;
    bit          saw_watch = 1'b0;

    // per-cycle samples
    logic        s_req, s_ack, s_adv, s_rvalid, s_flush, s_valid, s_ready, s_fault;
    logic [31:0] s_addr, s_instr, s_instr_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h0019_660D) ^ 32'h3C6E_F35F;
    endfunction

    function automatic exp_t expect_for(input logic [31:0] pc);
        exp_t e;
        if (pc[1:0] != 2'b00) e = '{instr: 32'h0000_0013, pc: pc, fault: 1'b1};
        else                  e = '{instr: mem_word(pc), pc: pc, fault: 1'b0};
        return e;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom & 32'h0000_0FFC;
        if ($urandom_range(7) == 0)  t[1:0] = 2'($urandom_range(3, 1));
        if ($urandom_range(15) == 0) t = 32'hFFFF_FFF8;
        return t;
    endfunction

    // One clock cycle: drive at negedge, sample and check 1 ns later,
    // update the model at the rising edge.
    task automatic step();
        exp_t e;
        @(negedge mp_clk_in);
        pc_in    = pc_reg;
        flush_in = 1'b0;
        if (flush_next) begin
            flush_in   = 1'b1;
            flush_next = 1'b0;
        end else if (flush_pct > 0 && int'($urandom_range(99)) < flush_pct) begin
            flush_in  = 1'b1;
            flush_tgt = rand_target();
        end
        bus.imem_ack_in = bus.imem_req_out && (force_ack || int'($urandom_range(99)) < ack_pct);
        if (pending && rv_cnt == 0) begin
            bus.imem_rvalid_in = 1'b1;
            bus.imem_rdata_in  = mem_word(rv_addr);
        end else begin
            bus.imem_rvalid_in = 1'b0;
            bus.imem_rdata_in  = $urandom;
        end
        bus.instr_ready_in = int'($urandom_range(99)) < ready_pct;
        #1;
        s_req      = bus.imem_req_out;
        s_addr     = bus.imem_addr_out;
        s_ack      = bus.imem_ack_in;
        s_adv      = pc_advance_out;
        s_rvalid   = bus.imem_rvalid_in;
        s_flush    = flush_in;
        s_valid    = bus.instr_valid_out;
        s_ready    = bus.instr_ready_in;
        s_instr    = bus.instr_out;
        s_instr_pc = bus.instr_pc_out;
        s_fault    = bus.instr_fault_out;

        if (s_req) begin
            check("req_addr", s_addr, pc_reg);
            check("single_outstanding", 32'(pending), 32'd0);
        end
        if (s_flush) check("flush_no_adv", 32'(s_adv), 32'd0);
        if (watch_en && s_valid && s_instr_pc == watch_pc) saw_watch = 1'b1;

        if (exp_q.size() == 0) begin
            check("empty_valid", 32'(s_valid), 32'd0);
        end else if (s_valid && s_ready) begin
            e = exp_q.pop_front();
            check("pop_instr", s_instr, e.instr);
            check("pop_pc", s_instr_pc, e.pc);
            check("pop_fault", 32'(s_fault), 32'(e.fault));
            pop_count++;
            last_pop_pc = s_instr_pc;
        end

        if (s_adv) begin
            if (pc_reg[1:0] == 2'b00) check("adv_with_ack", 32'(s_req && s_ack), 32'd1);
            else                      check("nop_no_req", 32'(s_req), 32'd0);
            exp_q.push_back(expect_for(pc_reg));
            check("reserve_bound", 32'(exp_q.size() <= FIFO_DEPTH), 32'd1);
        end

        @(posedge mp_clk_in);
        if (s_req && s_ack) begin
            pending       = 1'b1;
            rv_addr       = s_addr;
            rv_cnt        = lat_min + int'($urandom_range(lat_max - lat_min)) - 1;
            acc_count++;
            last_acc_addr = s_addr;
        end else if (pending) begin
            if (s_rvalid) begin
                pending = 1'b0;
                rvalid_count++;
            end else begin
                rv_cnt--;
            end
        end
        if (s_adv) adv_count++;
        if (s_flush) begin
            exp_q.delete();
            pc_reg = flush_tgt;
        end else if (s_adv) begin
            pc_reg = pc_reg + 32'd4;
        end
    endtask

    // Assert reset at a negedge (optionally checking outputs right away),
    // release just after a rising edge so the next step() sees the first cycle.
    task automatic do_reset(input logic [31:0] pc_hold, input logic [31:0] pc_start, input bit chk);
        @(negedge mp_clk_in);
        mp_rst_in          = 1'b0;
        pc_in              = pc_hold;
        flush_in           = 1'b0;
        bus.imem_ack_in    = 1'b0;
        bus.imem_rvalid_in = 1'b0;
        bus.imem_rdata_in  = '0;
        bus.instr_ready_in = 1'b0;
        #1;
        if (chk) begin
            check("rst_req", 32'(bus.imem_req_out), 32'd0);
            check("rst_addr", bus.imem_addr_out, 32'd0);
            check("rst_adv", 32'(pc_advance_out), 32'd0);
            check("rst_valid", 32'(bus.instr_valid_out), 32'd0);
            check("rst_instr", bus.instr_out, 32'd0);
            check("rst_instr_pc", bus.instr_pc_out, 32'd0);
            check("rst_fault", 32'(bus.instr_fault_out), 32'd0);
        end
        repeat (2) @(posedge mp_clk_in);
        #1;
        pc_reg     = pc_start;
        pc_in      = pc_start;
        exp_q.delete();
        pending    = 1'b0;
        flush_next = 1'b0;
        force_ack  = 1'b0;
        mp_rst_in  = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int base_acc, base_rv, base_pop, base_adv;
        bus.imem_ack_in    = 1'b0;
        bus.imem_rvalid_in = 1'b0;
        bus.imem_rdata_in  = '0;
        bus.instr_ready_in = 1'b0;

        // Reset values (misaligned pc_in held to exercise the fault path).
        do_reset(32'h6, 32'h0, 1'b1);

        // First fetch from 0: data two cycles after the ack.
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_valid) break;
        end
        check("t1_valid", 32'(s_valid), 32'd1);
        check("t1_instr", s_instr, 32'h0050_0093);
        check("t1_pc", s_instr_pc, 32'h0);
        check("t1_addr", last_acc_addr, 32'h0);
        check("t1_adv_count", 32'(adv_count), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1_hold_valid", 32'(s_valid), 32'd1);
            check("t1_hold_pc", s_instr_pc, 32'h0);
        end

        // Decode stalled: only FIFO_DEPTH fetches, then resume at 8.
        for (int i = 0; i < 20; i++) step();
        check("t2_adv_count", 32'(adv_count), 32'd2);
        check("t2_acc_count", 32'(acc_count), 32'd2);
        check("t2_no_req", 32'(s_req), 32'd0);
        base_pop  = pop_count;
        ready_pct = 100;
        for (int i = 0; i < 10 && pop_count < base_pop + 2; i++) step();
        check("t2_pops", 32'(pop_count - base_pop), 32'd2);
        for (int i = 0; i < 20 && acc_count < 3; i++) step();
        check("t2_resume_addr", last_acc_addr, 32'h8);

        // Flush while waiting for data from 0x10, redirect to 0x200.
        do_reset(32'h0, 32'h10, 1'b0);
        lat_min = 4; lat_max = 4; ready_pct = 100;
        base_acc = acc_count;
        for (int i = 0; i < 10 && acc_count < base_acc + 1; i++) step();
        check("t3_acc_0x10", last_acc_addr, 32'h10);
        base_rv    = rvalid_count;
        watch_en   = 1'b1; watch_pc = 32'h10; saw_watch = 1'b0;
        flush_next = 1'b1; flush_tgt = 32'h200;
        step();
        check("t3_flush_adv", 32'(s_adv), 32'd0);
        for (int i = 0; i < 30 && acc_count < base_acc + 2; i++) step();
        check("t3_redirect", last_acc_addr, 32'h200);
        check("t3_drain_rvalid", 32'(rvalid_count - base_rv), 32'd1);
        for (int i = 0; i < 10; i++) step();
        check("t3_no_stale", 32'(saw_watch), 32'd0);
        watch_en = 1'b0;

        // Flush in the same cycle as the ack.
        do_reset(32'h0, 32'h40, 1'b0);
        ack_pct = 0; lat_min = 2; lat_max = 2;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_req) break;
        end
        check("t4_req_seen", 32'(s_req), 32'd1);
        base_acc   = acc_count;
        base_rv    = rvalid_count;
        force_ack  = 1'b1;
        flush_next = 1'b1; flush_tgt = 32'h300;
        step();
        force_ack = 1'b0;
        ack_pct   = 100;
        check("t4_ack", 32'(s_ack), 32'd1);
        check("t4_adv", 32'(s_adv), 32'd0);
        for (int i = 0; i < 30 && acc_count < base_acc + 2; i++) step();
        check("t4_redirect", last_acc_addr, 32'h300);
        check("t4_one_rvalid", 32'(rvalid_count - base_rv), 32'd1);

        // Misaligned PC: fault NOP, no memory request.
        do_reset(32'h0, 32'h6, 1'b0);
        ready_pct = 0;
        step();
        check("t5_no_req", 32'(s_req), 32'd0);
        check("t5_adv", 32'(s_adv), 32'd1);
        step();
        check("t5_valid", 32'(s_valid), 32'd1);
        check("t5_instr", s_instr, 32'h0000_0013);
        check("t5_pc", s_instr_pc, 32'h6);
        check("t5_fault", 32'(s_fault), 32'd1);

        // Reset while in WAIT with one entry buffered.
        do_reset(32'h0, 32'h0, 1'b0);
        lat_min = 1; lat_max = 1;
        base_acc = acc_count;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_valid) break;
        end
        check("t6_buffered", 32'(s_valid), 32'd1);
        lat_min = 6; lat_max = 6;
        for (int i = 0; i < 20 && acc_count < base_acc + 2; i++) step();
        check("t6_second_acc", last_acc_addr, 32'h4);
        step();
        do_reset(32'h6, 32'h0, 1'b1);
        step();
        check("t6_fifo_empty", 32'(s_valid), 32'd0);

        // PC wrap through 0xFFFF_FFFC.
        do_reset(32'h0, 32'hFFFF_FFF8, 1'b0);
        lat_min = 1; lat_max = 1; ready_pct = 100;
        base_pop = pop_count;
        for (int i = 0; i < 40 && pop_count < base_pop + 3; i++) step();
        check("t7_wrap_pops", 32'(pop_count - base_pop), 32'd3);
        check("t7_wrap_pc", last_pop_pc, 32'h0);

        // Randomised traffic.
        do_reset(32'h0, 32'h0, 1'b0);
        ack_pct = 60; lat_min = 1; lat_max = 3; ready_pct = 60; flush_pct = 4;
        base_pop = pop_count;
        base_adv = adv_count;
        for (int i = 0; i < 3000; i++) step();
        check("rand_progress_pop", 32'(pop_count > base_pop + 100), 32'd1);
        check("rand_progress_adv", 32'(adv_count > base_adv + 100), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32_fetch_unit.md
Name: rv32_fetch_unit

Overview:
- Instruction fetch front end on the consumer side of the PC register.
- Takes the current PC (pc_in), issues word reads to instruction memory over a req/ack + rvalid handshake, and buffers returned instructions in a small FIFO for decode.
- Pulses pc_advance_out so the PC mux steps the PC register. Handles branch/jump flushes, including discarding an in-flight response.

Parameters:
- FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2).
- NOP_INSTR, 32'h0000_0013, instruction word substituted on a misaligned fetch.

Ports:
- mp_clk_in  input  1  clock, rising edge.
- mp_rst_in  input  1  asynchronous reset, active-low.
- pc_in  input  32  current PC from the PC register.
- pc_advance_out  output  1  one-cycle pulse: PC mux selects pc_in+4 for the next edge.
- flush_in  input  1  redirect: PC register loads the target on this same edge.
- imem_req_out  output  1  read request.
- imem_addr_out  output  32  word-aligned read address.
- imem_ack_in  input  1  request accepted this cycle.
- imem_rvalid_in  input  1  read data valid.
- imem_rdata_in  input  32  read data.
- instr_valid_out  output  1  FIFO head valid.
- instr_ready_in  input  1  decode accepts the head.
- instr_out  output  32  head instruction.
- instr_pc_out  output  32  PC of the head instruction.
- instr_fault_out  output  1  head entry came from a misaligned PC.

Behaviour:
- Reset (mp_rst_in=0, asynchronous):
  - FSM goes to IDLE; FIFO is emptied.
  - All outputs are 0, including imem_addr_out.
  - Reset asserted mid-transaction drops everything. Any later rvalid from the old request is the memory's responsibility; the memory is reset together with this block.
- FSM states: IDLE, REQ, WAIT, DRAIN. At most one request is outstanding.
- IDLE:
  - If the FIFO has a free slot and flush_in=0:
    - pc_in[1:0]==0: latch pc_in into the address register, go to REQ.
    - Otherwise: push {NOP_INSTR, pc_in, fault=1}, pulse pc_advance_out, stay in IDLE. No memory request is issued.
- REQ:
  - imem_req_out=1 and imem_addr_out is held stable until imem_ack_in.
  - On ack: pc_advance_out=1 in the same cycle, go to WAIT.
- WAIT:
  - On imem_rvalid_in: push {imem_rdata_in, latched addr, fault=0}, go to IDLE.
  - Earliest back-to-back case: a response in cycle N lets IDLE issue in N+1, giving one request per 2 cycles plus memory latency.
- Free-slot rule: a slot is reserved at request issue, so a push never finds the FIFO full. Reserved count = occupancy + (state is REQ or WAIT).
- Flush (flush_in=1), with priority over all else this cycle:
  - The FIFO is cleared and instr_valid_out falls to 0 on the next edge.
  - IDLE: stay in IDLE. The next request uses the redirected pc_in from the next cycle.
  - REQ, no ack this cycle: drop the request, go to IDLE.
  - REQ with ack this cycle, or WAIT: go to DRAIN.
  - Under flush, pc_advance_out is forced to 0.
  - In WAIT with rvalid in the same cycle as flush: the data is discarded and the FSM goes to IDLE.
- DRAIN:
  - Wait for imem_rvalid_in, discard the data, go to IDLE.
  - A further flush_in in DRAIN keeps the FSM in DRAIN.
- FIFO:
  - Pop when instr_valid_out && instr_ready_in.
  - A simultaneous push and pop is allowed at any occupancy.
  - Pointers are log2(FIFO_DEPTH)-bit and wrap naturally; the count is one bit wider.
  - Outputs are driven from the head entry. With the FIFO empty, instr_out and instr_pc_out hold their last value and carry no meaning.
- Address arithmetic: 32-bit. A PC of 32'hFFFF_FFFC wraps through the PC mux without a fault.

Decomposition:
- Shared package rv32_fetch_pkg holds:
  - the state enum (IDLE/REQ/WAIT/DRAIN);
  - the NOP_INSTR constant;
  - the fetch entry struct {instr[31:0], pc[31:0], fault}.
- One sub-module, rv32_fetch_fifo: a parameterised synchronous FIFO with clear, push, pop, count and head outputs, on the same clock and async active-low reset.

Test Plan:
- Reset then pc_in=0, memory acks after 0 cycles and returns data 2 cycles later with 32'h00500093 → imem_addr_out=0, one pc_advance_out pulse, instr_out=32'h00500093, instr_pc_out=0, valid until ready.
- instr_ready_in held 0, pc stepping 0,4,8 → exactly FIFO_DEPTH=2 entries (PCs 0,4) are fetched and no third req is issued. Raising ready drains them in order, then fetching at 8 resumes.
- flush_in asserted in WAIT for addr 32'h10, with pc_in redirected to 32'h200 → DRAIN; the returning data for 32'h10 never appears on instr_out; the next request address is 32'h200.
- flush_in in the same cycle as imem_ack_in → pc_advance_out=0, FSM goes to DRAIN; after one rvalid the next request is at the target PC.
- pc_in=32'h0000_0006 → no imem_req_out; an entry with instr_out=32'h00000013, instr_pc_out=6, instr_fault_out=1; one pc_advance_out pulse.
- Reset deasserted to asserted while in WAIT with 1 entry buffered → all outputs go to 0 immediately and the FIFO is empty after release.
